// File: rtl/clock_monitor_pkg.sv
// Shared types and constants for the clock monitor and its users.
package clock_monitor_pkg;

    // Measurement FSM: IDLE waits for an arming edge, MEASURE times periods.
    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    // Default counter width and its saturation value.
    localparam int                       DEF_CNT_WIDTH = 16;
    localparam logic [DEF_CNT_WIDTH-1:0] CNT_MAX       = '1;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-stage synchronizer for an asynchronous level, followed by a history
// flop that turns transitions into single-cycle rise/fall pulses. Both edges
// see the same latency, so intervals measured between pulses are unbiased.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;

    // Shift the async input through the synchronizer, then into the history flop.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign level = r_sync[SYNC_STAGES-1];
    assign rise  = level & ~r_hist;
    assign fall  = ~level & r_hist;

endmodule

// File: rtl/clock_monitor.sv
// Measures period and high time of a slow asynchronous clock in clk_in
// cycles, and flags loss of that clock after TIMEOUT cycles without a rise.
module clock_monitor
    import clock_monitor_pkg::*;
#(
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1000
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 mon_clk,
    output logic [CNT_WIDTH-1:0] period,
    output logic [CNT_WIDTH-1:0] high_time,
    output logic                 valid,
    output logic                 clk_lost
);

    localparam logic [CNT_WIDTH-1:0] W_CNT_MAX = '1;
    localparam logic [CNT_WIDTH:0]   W_ONE     = {{CNT_WIDTH{1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH:0]   W_TMO     = (CNT_WIDTH+1)'(TIMEOUT);

    logic                 w_unused_level;
    logic                 w_rise;
    logic                 w_fall;
    logic [CNT_WIDTH:0]   w_cnt_inc;
    logic [CNT_WIDTH-1:0] w_meas;
    logic                 w_timeout;

    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_hi_lat;
    logic [CNT_WIDTH-1:0] r_period;
    logic [CNT_WIDTH-1:0] r_high_time;
    logic                 r_valid;
    logic                 r_clk_lost;
    state_t               r_state;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_in  (clk_in),
        .rst     (rst),
        .async_in(mon_clk),
        .level   (w_unused_level),
        .rise    (w_rise),
        .fall    (w_fall)
    );

    // cnt+1 is kept one bit wider so a saturated counter never matches TIMEOUT.
    assign w_cnt_inc = {1'b0, r_cnt} + W_ONE;
    assign w_meas    = (r_cnt == W_CNT_MAX) ? W_CNT_MAX : w_cnt_inc[CNT_WIDTH-1:0];
    assign w_timeout = (w_cnt_inc == W_TMO);

    // Cycles since the last rise: cleared on rise or while disabled, saturating.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (!en || w_rise) begin
            r_cnt <= '0;
        end else if (r_cnt != W_CNT_MAX) begin
            r_cnt <= w_cnt_inc[CNT_WIDTH-1:0];
        end
    end

    // Arm on the first rise, then publish a measurement on every later rise;
    // a missing rise for TIMEOUT cycles flags loss and drops back to IDLE.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_hi_lat    <= '0;
            r_period    <= '0;
            r_high_time <= '0;
            r_valid     <= 1'b0;
            r_clk_lost  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (!en) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_rise) begin
                            r_state    <= MEASURE;
                            r_clk_lost <= 1'b0;
                        end else if (w_timeout) begin
                            r_clk_lost <= 1'b1;
                        end
                    end
                    MEASURE: begin
                        if (w_rise) begin
                            r_period    <= w_meas;
                            r_high_time <= r_hi_lat;
                            r_valid     <= 1'b1;
                        end else begin
                            if (w_fall) begin
                                r_hi_lat <= w_meas;
                            end
                            if (w_timeout) begin
                                r_clk_lost <= 1'b1;
                                r_state    <= IDLE;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign period    = r_period;
    assign high_time = r_high_time;
    assign valid     = r_valid;
    assign clk_lost  = r_clk_lost;

endmodule

// File: tb/tb_clock_monitor.sv
// Directed bench for clock_monitor: vector table of mon_clk shapes plus
// hand-written loss/recovery, mid-run reset and enable-gating sequences.
module tb_clock_monitor;

    localparam int CW = 16;
    localparam int SS = 2;
    localparam int TO = 1000;

    logic          clk_in  = 1'b0;
    logic          rst     = 1'b0;
    logic          en      = 1'b1;
    logic          mon_clk = 1'b0;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          valid;
    logic          clk_lost;

    clock_monitor #(
        .CNT_WIDTH  (CW),
        .SYNC_STAGES(SS),
        .TIMEOUT    (TO)
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .en       (en),
        .mon_clk  (mon_clk),
        .period   (period),
        .high_time(high_time),
        .valid    (valid),
        .clk_lost (clk_lost)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_valid = 0;
    int last_rise_cyc = 0;
    bit mon_on  = 1'b0;
    int hi_cyc  = 5;
    int lo_cyc  = 5;
    int ph      = 0;
    int exp_period = 10;
    int exp_high   = 5;

    typedef struct {
        int hi;
        int lo;
        int exp_p;
        int exp_h;
    } vec_t;
    vec_t vecs [6];

    // 10 ns reference clock, rising edges at 5, 15, 25 ...
    initial forever #5 clk_in = ~clk_in;

    initial forever begin
        @(posedge clk_in);
        cyc++;
    end

    // mon_clk generator: edges 2 ns after a clk_in rise, shape in whole cycles.
    initial forever begin
        @(posedge clk_in);
        #2;
        if (mon_on) begin
            if (ph == 0) last_rise_cyc = cyc;
            mon_clk = (ph < hi_cyc);
            ph = (ph + 1 == hi_cyc + lo_cyc) ? 0 : ph + 1;
        end else begin
            mon_clk = 1'b0;
            ph = 0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every valid pulse is one transaction: check it against the expectation.
    initial forever begin
        @(negedge clk_in);
        if (rst && valid) begin
            n_valid++;
            $display("[TB] cyc %0d valid: period=%0d high_time=%0d (exp %0d/%0d)",
                     cyc, period, high_time, exp_period, exp_high);
            check("valid.period", int'(period), exp_period);
            check("valid.high_time", int'(high_time), exp_high);
        end
    end

    // 18 ns reset pulse placed between clk_in edges; outputs must clear at once.
    task automatic pulse_reset(input string tag);
        @(negedge clk_in);
        #3 rst = 1'b0;
        #1;
        check({tag, ".rst_period"}, int'(period), 0);
        check({tag, ".rst_high_time"}, int'(high_time), 0);
        check({tag, ".rst_valid"}, int'(valid), 0);
        check({tag, ".rst_clk_lost"}, int'(clk_lost), 0);
        #17 rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got t=%0t expected < 2ms", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lost_at;
        int v0;
        int p;

        vecs[0] = '{hi: 5,  lo: 5,  exp_p: 10, exp_h: 5};
        vecs[1] = '{hi: 3,  lo: 13, exp_p: 16, exp_h: 3};
        vecs[2] = '{hi: 2,  lo: 2,  exp_p: 4,  exp_h: 2};
        vecs[3] = '{hi: 7,  lo: 3,  exp_p: 10, exp_h: 7};
        vecs[4] = '{hi: 1,  lo: 2,  exp_p: 3,  exp_h: 1};
        vecs[5] = '{hi: 12, lo: 20, exp_p: 32, exp_h: 12};

        // Reset and idle: loss after exactly TIMEOUT cycles, never a valid.
        #29;
        check("reset.period", int'(period), 0);
        check("reset.high_time", int'(high_time), 0);
        check("reset.valid", int'(valid), 0);
        check("reset.clk_lost", int'(clk_lost), 0);
        #1 rst = 1'b1;
        lost_at = -1;
        for (int n = 1; n <= 1200; n++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            if (clk_lost) begin
                lost_at = n;
                break;
            end
        end
        check("idle.lost_cycle", lost_at, TO);
        check("idle.no_valid", n_valid, 0);

        // Vector table: six generated rises give five measurements.
        for (int v = 0; v < 6; v++) begin
            mon_on = 1'b0;
            repeat (4) @(posedge clk_in);
            pulse_reset("vec");
            hi_cyc     = vecs[v].hi;
            lo_cyc     = vecs[v].lo;
            exp_period = vecs[v].exp_p;
            exp_high   = vecs[v].exp_h;
            p  = hi_cyc + lo_cyc;
            v0 = n_valid;
            @(posedge clk_in);
            #1 mon_on = 1'b1;
            repeat (6 * p) @(posedge clk_in);
            #1 mon_on = 1'b0;
            repeat (10) @(posedge clk_in);
            @(negedge clk_in);
            check("vec.valid_count", n_valid - v0, 5);
            check("vec.clk_lost", int'(clk_lost), 0);
        end

        // Loss and recovery with a steady 10-cycle clock.
        mon_on = 1'b0;
        repeat (4) @(posedge clk_in);
        pulse_reset("loss");
        hi_cyc = 5; lo_cyc = 5; exp_period = 10; exp_high = 5;
        @(posedge clk_in);
        #1 mon_on = 1'b1;
        repeat (40) @(posedge clk_in);
        #1 mon_on = 1'b0;
        lost_at = -1;
        for (int n = 0; n < 1200; n++) begin
            @(negedge clk_in);
            if (clk_lost) begin
                lost_at = cyc - last_rise_cyc;
                break;
            end
        end
        check("loss.latency", lost_at, TO + SS + 1);
        check("loss.period_held", int'(period), 10);
        check("loss.high_held", int'(high_time), 5);
        v0 = n_valid;
        @(posedge clk_in);
        #1 mon_on = 1'b1;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        check("recover.still_lost", int'(clk_lost), 1);
        @(posedge clk_in);
        @(negedge clk_in);
        check("recover.lost_cleared", int'(clk_lost), 0);
        check("recover.no_valid_first_rise", n_valid - v0, 0);
        repeat (14) @(posedge clk_in);
        @(negedge clk_in);
        check("recover.one_valid", n_valid - v0, 1);

        // Reset mid-operation, applied while mon_clk is low.
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_in);
            #3;
            if (ph == 9) break;
        end
        pulse_reset("midrst");
        v0 = n_valid;
        repeat (8) @(posedge clk_in);
        @(negedge clk_in);
        check("midrst.no_valid_early", n_valid - v0, 0);
        repeat (10) @(posedge clk_in);
        @(negedge clk_in);
        check("midrst.one_valid", n_valid - v0, 1);

        // Enable gating: 50 cycles disabled, then re-arm on the next rise.
        @(posedge clk_in);
        #1 en = 1'b0;
        v0 = n_valid;
        repeat (50) @(posedge clk_in);
        @(negedge clk_in);
        check("en.no_valid", n_valid - v0, 0);
        check("en.clk_lost", int'(clk_lost), 0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_in);
            #3;
            if (ph == 9) break;
        end
        en = 1'b1;
        v0 = n_valid;
        repeat (8) @(posedge clk_in);
        @(negedge clk_in);
        check("en.no_valid_first_rise", n_valid - v0, 0);
        repeat (12) @(posedge clk_in);
        @(negedge clk_in);
        check("en.one_valid", n_valid - v0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
